dec_scan_ctrl: RTL and testbench

Sequencer that drives the three select inputs (in1, in2, in3) of the team's 3-to-8 decoder (latch_2). It steps through the eight decoder outputs in ascending index order, skips channels disabled by a mask, and holds each selected code for a programmable dwell. A blanking gap follows each dwell. It supports one-shot and continuous frame scanning, plus start and abort pulses.

---
 rtl/dec_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_dec_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_ctrl.sv
// Purpose: walks the 3-to-8 decoder select lines through the enabled channels with a dwell/gap cadence.
// Latency: code and code_vld are valid in the cycle after the start edge; all outputs are registered.
// Backpressure: none; start is ignored while busy and stop aborts to idle from any state.
module dec_scan_ctrl #(
    parameter int CNT_W = 16,
    parameter int DWELL = 10,
    parameter int GAP   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [7:0] mask,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       code_vld,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    logic [1:0]       state, state_nx;
    logic [2:0]       cur, cur_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       mask_r, mask_nx;
    logic             cont_r, cont_nx;
    logic             fd_nx;

    logic [2:0]       first_in;   // lowest enabled channel of the live mask input
    logic [2:0]       first_r;    // lowest enabled channel of the frame's mask
    logic [2:0]       last_r;     // highest enabled channel of the frame's mask
    logic [2:0]       next_r;     // next enabled channel above cur, wrapping to first_r

    // Channel search over the input mask and the captured frame mask.
    always_comb begin
        first_in = 3'd0;
        first_r  = 3'd0;
        last_r   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i])   first_in = 3'(i);
            if (mask_r[i]) first_r  = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (mask_r[i]) last_r = 3'(i);
        end
        next_r = first_r;
        for (int i = 7; i >= 0; i--) begin
            if (mask_r[i] && (3'(i) > cur)) next_r = 3'(i);
        end
    end

    // Next-state logic for the scan sequence; stop overrides everything.
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        cnt_nx   = cnt;
        mask_nx  = mask_r;
        cont_nx  = cont_r;
        fd_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (mask != 8'd0)) begin
                    mask_nx  = mask;
                    cont_nx  = cont;
                    cur_nx   = first_in;
                    cnt_nx   = '0;
                    state_nx = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_GAP;
                    fd_nx    = (cur == last_r);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx = '0;
                    if (cur != last_r) begin
                        cur_nx   = next_r;
                        state_nx = S_DWELL;
                    end else if (cont_r && (mask != 8'd0)) begin
                        // Frame boundary in continuous mode: pick up the new mask.
                        mask_nx  = mask;
                        cur_nx   = first_in;
                        state_nx = S_DWELL;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (stop) begin
            state_nx = S_IDLE;
            cur_nx   = 3'd0;
            cnt_nx   = '0;
            fd_nx    = 1'b0;
        end
    end

    // State and registered outputs, all derived from the next-state values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            cur        <= 3'd0;
            cnt        <= '0;
            mask_r     <= 8'd0;
            cont_r     <= 1'b0;
            code_vld   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cur        <= cur_nx;
            cnt        <= cnt_nx;
            mask_r     <= mask_nx;
            cont_r     <= cont_nx;
            code_vld   <= (state_nx == S_DWELL);
            busy       <= (state_nx != S_IDLE);
            frame_done <= fd_nx;
        end
    end

    assign in1 = cur[2];
    assign in2 = cur[1];
    assign in3 = cur[0];

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: frame-position reference model compared every cycle, plus literal timing checks.
// Latency: model outputs reflect each rising edge and are compared on the following falling edge.
// Backpressure: not applicable; stimulus is free-running pulses and masks.
module tb_dec_scan_ctrl;

    localparam int DW = 10;
    localparam int GP = 2;
    localparam int P  = DW + GP;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] mask = 8'd0;
    logic       in1, in2, in3, code_vld, busy, frame_done;

    int tests = 0;
    int fails = 0;

    dec_scan_ctrl #(.CNT_W(16), .DWELL(DW), .GAP(GP)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .cont(cont), .mask(mask), .in1(in1), .in2(in2), .in3(in3),
        .code_vld(code_vld), .busy(busy), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: a frame is a list of enabled channels and a cycle position within it.
    int         chans[$];
    bit         m_active;
    int         m_t;
    bit         m_cont;
    logic [2:0] m_code;
    bit         m_vld, m_busy, m_fd;

    function automatic void load_frame(input logic [7:0] m);
        chans.delete();
        for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_active = 0; m_t = 0; m_cont = 0; m_code = 3'd0;
            m_vld = 0; m_busy = 0; m_fd = 0;
            chans.delete();
        end else begin
            if (stop) begin
                m_active = 0;
                m_code = 3'd0;
            end else if (!m_active) begin
                if (start && mask != 8'd0) begin
                    load_frame(mask);
                    m_cont = cont;
                    m_t = 0;
                    m_active = 1;
                end
            end else begin
                m_t++;
                if (m_t == chans.size() * P) begin
                    if (m_cont && mask != 8'd0) begin
                        load_frame(mask);
                        m_t = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end
            if (m_active) begin
                m_code = 3'(chans[m_t / P]);
                m_vld  = (m_t % P) < DW;
                m_fd   = ((m_t % P) == DW) && ((m_t / P) == chans.size() - 1);
            end else begin
                m_vld = 0;
                m_fd  = 0;
            end
            m_busy = m_active;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sys_clk) begin
        logic [5:0] got, exp;
        got = {in1, in2, in3, code_vld, busy, frame_done};
        exp = {m_code, m_vld, m_busy, m_fd};
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails < 20)
                $display("FAIL model_cmp t=%0t got code=%0d vld=%b busy=%b fd=%b expected code=%0d vld=%b busy=%b fd=%b",
                         $time, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic c);
        mask = m; cont = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int fd_at, busy_low_at, fd_count;
    int codes[$];
    int fds[$];
    bit prev_vld;

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {in1, in2, in3, code_vld, busy, frame_done}, 0);
        sys_rst_n = 1'b1;
        tick();

        // One-shot full-mask frame: frame_done at +94, busy low at +96
        pulse_start(8'hFF, 1'b0);
        fd_at = -1; busy_low_at = -1; fd_count = 0;
        for (int n = 1; n <= 110; n++) begin
            tick();
            if (frame_done) begin
                fd_count++;
                if (fd_at < 0) fd_at = n;
            end
            if (!busy && busy_low_at < 0) busy_low_at = n;
        end
        check("oneshot_fd_cycle", fd_at, 94);
        check("oneshot_fd_count", fd_count, 1);
        check("oneshot_busy_low", busy_low_at, 96);

        // Continuous sparse mask, then switch to a single channel mid-frame
        pulse_start(8'b1010_0100, 1'b1);
        codes.delete(); fds.delete(); prev_vld = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            tick();
            if (code_vld && !prev_vld) codes.push_back({in1, in2, in3});
            prev_vld = code_vld;
            if (frame_done) fds.push_back(n);
            if (n == 80) mask = 8'h01;
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("cont_code[%0d]", i), (codes.size() > i) ? codes[i] : -1, (i % 3 == 0) ? 2 : ((i % 3 == 1) ? 5 : 7));
        begin
            int exp_fd[6];
            exp_fd = '{34, 70, 106, 118, 130, 142};
            for (int i = 0; i < 6; i++)
                check($sformatf("cont_fd[%0d]", i), (fds.size() > i) ? fds[i] : -1, exp_fd[i]);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("cont_stop_busy", busy, 0);

        // Stop during the 5th dwell cycle of code 3
        pulse_start(8'hFF, 1'b0);
        for (int n = 1; n <= 40; n++) tick();
        check("pre_stop_code", {in1, in2, in3}, 3);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_outputs", {in1, in2, in3, code_vld, busy, frame_done}, 0);
        // start and stop together
        mask = 8'hFF; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 0);

        // start with empty mask
        pulse_start(8'h00, 1'b1);
        tick();
        check("empty_mask_busy", busy, 0);

        // start while busy is ignored (model checks timing)
        pulse_start(8'h81, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin mask = 8'h3C; cont = 1'b1; start = 1'b1; end
            tick();
            start = 1'b0;
        end

        // Asynchronous reset mid-GAP
        tick();
        pulse_start(8'hFF, 1'b1);
        for (int n = 1; n <= 10; n++) tick();
        check("pre_reset_gap", {code_vld, busy}, 1);
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {in1, in2, in3, code_vld, busy, frame_done}, 0);
        tick(); tick();
        sys_rst_n = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        check("post_reset_idle", busy, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            cont  = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0)
                mask = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            tick();
        end
        start = 1'b0; stop = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
